sdft_scheduler: RTL and testbench
=================================

# sdft_scheduler

Front-end controller for the sliding-DFT datapath. Accepts audio samples through a valid/ready handshake and buffers them in a small FIFO. Owns the circular sample-history RAM, fetching the oldest sample and writing back the newest. Issues one compute job per sample to the per-bin datapath, waits for its completion, and flags one job in every DISP_PERIOD as a display frame.

## Interface
Parameters:
- WORD_WIDTH, 16, sample width (signed)
- FFT_SIZE, 256, bins and history depth; power of two
- FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2
- DISP_PERIOD, 4410, samples per display frame

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  sample offered
- s_ready  out  1  FIFO not full
- s_data  in  WORD_WIDTH  signed sample
- hist_rd_en  out  1  history read strobe
- hist_rd_addr  out  log2(FFT_SIZE)  read address
- hist_rd_data  in  WORD_WIDTH  read data, valid one cycle after hist_rd_en
- hist_wr_en  out  1  history write strobe
- hist_wr_addr  out  log2(FFT_SIZE)  write address
- hist_wr_data  out  WORD_WIDTH  write data
- job_start  out  1  one-cycle job launch pulse
- job_sample  out  WORD_WIDTH  newest sample, held from job_start until job_done
- job_oldest  out  WORD_WIDTH  evicted sample, held likewise
- job_done  in  1  datapath pulse after its last bin
- disp_wr_en  out  1  current job is a display frame; held from job_start until job_done
- frame_pulse  out  1  one cycle after a display-frame job completes
- drop_count  out  16  saturating count of dropped samples

## Operation
- FSM states and transitions:
  - IDLE: go to FETCH when the FIFO is non-empty.
  - FETCH: assert hist_rd_en with hist_rd_addr=ptr; pop the FIFO head into the sample register; go to READ.
  - READ: capture hist_rd_data; go to LAUNCH.
  - LAUNCH: pulse job_start; write hist_wr_en, hist_wr_addr=ptr, hist_wr_data=sample; go to WAIT.
  - WAIT: hold until job_done. On job_done, go to FETCH if the FIFO is non-empty, else IDLE.
- ptr: increments mod FFT_SIZE on each job_done and wraps from FFT_SIZE-1 to 0.
- Warm-up: a fill counter saturates at FFT_SIZE. While fill<FFT_SIZE, job_oldest is forced to 0 instead of using the uninitialised RAM data.
- Display counter:
  - Counts 0..DISP_PERIOD-1 and increments on job_done.
  - Wraps to 0 after the job completes while the count equals DISP_PERIOD-1.
  - disp_wr_en is high for the job launched while the count equals DISP_PERIOD-1.
  - frame_pulse fires in the cycle after that job's job_done.
- job_done outside WAIT is ignored.
- Input handshake:
  - A sample is accepted when s_valid&&s_ready.
  - s_ready is low when the FIFO is full. A push and a pop in the same cycle are legal whenever the FIFO is not full.
  - s_valid&&!s_ready drops the sample; the source is a non-stallable ADC.
- Reset:
  - Reset mid-job returns every register to its reset value and empties the FIFO.
  - The datapath shares reset_n, so no orphaned job_done can occur.

## Timing
- Reset values:
  - State IDLE; ptr, fill, display counter and drop_count 0; FIFO empty.
  - s_ready 1; all strobes and pulses 0; job_sample, job_oldest and hist_* data/address 0.
- Latency:
  - Sample accepted in cycle t into an empty FIFO with the FSM in IDLE: hist_rd_en in t+2, job_start in t+4.
  - Back-to-back jobs: job_done in cycle d with the FIFO non-empty gives the next job_start in d+3.
- All outputs are registered.

## Configuration
- SDFT_DROP_COUNT_EN defined: drop_count increments on every s_valid&&!s_ready and saturates at 16'hFFFF.
- SDFT_DROP_COUNT_EN undefined: drop_count is tied to 0 and no counter logic is built. Handshake behaviour is identical in both builds.

## Structure
- Shared package sdft_pkg contains:
  - the FSM state encoding;
  - the default FFT_SIZE and DISP_PERIOD constants;
  - the address-width constant log2(FFT_SIZE), shared with the datapath and twiddle address generator.
- One sub-module, sdft_sample_fifo: a synchronous FIFO with full/empty flags and a registered head, parameterised by WORD_WIDTH and FIFO_DEPTH.

## Test plan
- Single sample 100 after reset, job_done returned 10 cycles after job_start:
  - job_start at t+4 with job_sample=100 and job_oldest=0;
  - hist write to address 0; ptr becomes 1.
- FFT_SIZE+1 samples 1..257:
  - job 257 has job_oldest=1, read from address 0;
  - the hist write targets address 0, confirming wrap.
- 4410 samples:
  - disp_wr_en high only on job 4410, with one frame_pulse after its done;
  - the counter is back at 0, so job 8820 is flagged again.
- Datapath held busy while 6 samples arrive at FIFO_DEPTH=4:
  - s_ready falls after 4 accepts;
  - 2 dropped, so drop_count=2 with the macro and 0 without;
  - the 4 queued jobs run in order.
- reset_n asserted in WAIT:
  - all outputs at reset values immediately (asynchronous);
  - s_ready=1 and the FIFO empty after release;
  - the next sample writes address 0.

Source files
------------

// File: rtl/sdft_pkg.sv
// rtl/sdft_pkg.sv - shared constants and FSM encoding for the sliding-DFT front end
package sdft_pkg;

    // Scheduler FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_READ,
        ST_LAUNCH,
        ST_WAIT
    } sdft_state_t;

    // Default transform size (bins and history depth) and display frame period
    localparam int SDFT_FFT_SIZE    = 256;
    localparam int SDFT_DISP_PERIOD = 4410;

    // Bin / history address width, shared with the datapath and twiddle address generator
    localparam int SDFT_ADDR_W = $clog2(SDFT_FFT_SIZE);

endpackage

// File: rtl/sdft_sample_fifo.sv
// rtl/sdft_sample_fifo.sv - synchronous sample FIFO with registered flags
// Ports: clk, reset_n (async active-low); push/push_data write side;
//        pop/head read side (head is the oldest entry, read from flop storage);
//        empty and not_full are registered flags.
module sdft_sample_fifo #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [WORD_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  not_full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  do_push;
    logic                  do_pop;

    // A push is refused only when full; a simultaneous pop does not make room early.
    assign do_push = push && not_full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            not_full <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count_next;
            empty    <= (count_next == '0);
            not_full <= (count_next != CW'(FIFO_DEPTH));
        end
    end

endmodule

// File: rtl/sdft_scheduler.sv
// rtl/sdft_scheduler.sv - front-end scheduler for the sliding-DFT datapath
// Ports: clk, reset_n (async active-low);
//        s_valid/s_ready/s_data      sample input, non-stallable source;
//        hist_rd_*/hist_wr_*         circular history RAM access;
//        job_start/job_sample/job_oldest/job_done  datapath job handshake;
//        disp_wr_en/frame_pulse      display frame marking;
//        drop_count                  saturating dropped-sample count.
// Option: SDFT_DROP_COUNT_EN builds the drop counter; otherwise drop_count is 0.
module sdft_scheduler
    import sdft_pkg::*;
#(
    parameter int WORD_WIDTH  = 16,
    parameter int FFT_SIZE    = SDFT_FFT_SIZE,
    parameter int FIFO_DEPTH  = 4,
    parameter int DISP_PERIOD = SDFT_DISP_PERIOD
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [WORD_WIDTH-1:0]       s_data,
    output logic                        hist_rd_en,
    output logic [$clog2(FFT_SIZE)-1:0] hist_rd_addr,
    input  logic [WORD_WIDTH-1:0]       hist_rd_data,
    output logic                        hist_wr_en,
    output logic [$clog2(FFT_SIZE)-1:0] hist_wr_addr,
    output logic [WORD_WIDTH-1:0]       hist_wr_data,
    output logic                        job_start,
    output logic [WORD_WIDTH-1:0]       job_sample,
    output logic [WORD_WIDTH-1:0]       job_oldest,
    input  logic                        job_done,
    output logic                        disp_wr_en,
    output logic                        frame_pulse,
    output logic [15:0]                 drop_count
);

    localparam int AW = $clog2(FFT_SIZE);
    localparam int FW = AW + 1;
    localparam int DW = (DISP_PERIOD > 1) ? $clog2(DISP_PERIOD) : 1;

    sdft_state_t           state;
    logic [AW-1:0]         ptr;
    logic [FW-1:0]         fill;
    logic [DW-1:0]         disp_cnt;
    logic                  disp_last;
    logic                  history_full;
    logic [WORD_WIDTH-1:0] sample_q;
    logic [WORD_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  fifo_not_full;
    logic                  fifo_pop;

    assign fifo_pop     = (state == ST_FETCH);
    assign s_ready      = fifo_not_full;
    assign disp_last    = (disp_cnt == DW'(DISP_PERIOD - 1));
    assign history_full = (fill == FW'(FFT_SIZE));

    sdft_sample_fifo #(
        .WORD_WIDTH (WORD_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .not_full  (fifo_not_full)
    );

    // Strobes are set on the transition into the state that owns them, so each
    // appears registered in exactly that state's cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            fill         <= '0;
            disp_cnt     <= '0;
            sample_q     <= '0;
            hist_rd_en   <= 1'b0;
            hist_rd_addr <= '0;
            hist_wr_en   <= 1'b0;
            hist_wr_addr <= '0;
            hist_wr_data <= '0;
            job_start    <= 1'b0;
            job_sample   <= '0;
            job_oldest   <= '0;
            disp_wr_en   <= 1'b0;
            frame_pulse  <= 1'b0;
        end else begin
            hist_rd_en  <= 1'b0;
            hist_wr_en  <= 1'b0;
            job_start   <= 1'b0;
            frame_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state        <= ST_FETCH;
                        hist_rd_en   <= 1'b1;
                        hist_rd_addr <= ptr;
                    end
                end
                ST_FETCH: begin
                    sample_q <= fifo_head;
                    state    <= ST_READ;
                end
                ST_READ: begin
                    // RAM data for ptr is valid now; until the history has been
                    // filled once, that slot was never written, so evict zero.
                    job_start    <= 1'b1;
                    job_sample   <= sample_q;
                    job_oldest   <= history_full ? hist_rd_data : '0;
                    hist_wr_en   <= 1'b1;
                    hist_wr_addr <= ptr;
                    hist_wr_data <= sample_q;
                    disp_wr_en   <= disp_last;
                    state        <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (job_done) begin
                        ptr         <= ptr + AW'(1);
                        fill        <= history_full ? fill : fill + FW'(1);
                        disp_cnt    <= disp_last ? '0 : disp_cnt + DW'(1);
                        frame_pulse <= disp_wr_en;
                        disp_wr_en  <= 1'b0;
                        if (!fifo_empty) begin
                            state        <= ST_FETCH;
                            hist_rd_en   <= 1'b1;
                            hist_rd_addr <= ptr + AW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SDFT_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (s_valid && !fifo_not_full && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_sdft_scheduler.sv
// tb/tb_sdft_scheduler.sv - self-checking bench for sdft_scheduler
module tb_sdft_scheduler;

    localparam int N    = 256;
    localparam int P    = 4410;
    localparam int MAXJ = 9000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        hist_rd_en;
    logic [7:0]  hist_rd_addr;
    logic [15:0] hist_rd_data = '0;
    logic        hist_wr_en;
    logic [7:0]  hist_wr_addr;
    logic [15:0] hist_wr_data;
    logic        job_start;
    logic [15:0] job_sample;
    logic [15:0] job_oldest;
    logic        job_done = 1'b0;
    logic        disp_wr_en;
    logic        frame_pulse;
    logic [15:0] drop_count;

    sdft_scheduler #(
        .WORD_WIDTH  (16),
        .FFT_SIZE    (N),
        .FIFO_DEPTH  (4),
        .DISP_PERIOD (P)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .hist_rd_en   (hist_rd_en),
        .hist_rd_addr (hist_rd_addr),
        .hist_rd_data (hist_rd_data),
        .hist_wr_en   (hist_wr_en),
        .hist_wr_addr (hist_wr_addr),
        .hist_wr_data (hist_wr_data),
        .job_start    (job_start),
        .job_sample   (job_sample),
        .job_oldest   (job_oldest),
        .job_done     (job_done),
        .disp_wr_en   (disp_wr_en),
        .frame_pulse  (frame_pulse),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // History RAM seen by the DUT; preloaded with junk so warm-up zeroing matters.
    logic [15:0] ram [N];
    always @(posedge clk) begin
        if (hist_wr_en) ram[hist_wr_addr] <= hist_wr_data;
        if (hist_rd_en) hist_rd_data <= ram[hist_rd_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: accepted samples in order, a history array,
    // write pointer, fill level and display counter advanced once per job.
    typedef struct {
        logic [15:0] v;
        int          acc;
    } item_t;

    item_t       exp_q[$];
    logic [15:0] mhist [N];
    int          m_ptr, m_fill, m_dcnt, last_done;
    bit          busy, cur_disp, frame_exp, hold, stray;
    int          cnt_dn, done_dly, jobs, frames;
    int          last_rd_cyc;
    logic [7:0]  last_rd_addr;

    logic [15:0] j_sample [MAXJ];
    logic [15:0] j_old    [MAXJ];
    logic [7:0]  j_wr_addr[MAXJ];
    logic [7:0]  j_rd_addr[MAXJ];
    bit          j_disp   [MAXJ];
    int          j_start  [MAXJ];
    int          j_rd_cyc [MAXJ];

    task automatic model_reset();
        exp_q.delete();
        m_ptr = 0; m_fill = 0; m_dcnt = 0; last_done = -100;
        busy = 0; frame_exp = 0; cnt_dn = 0; jobs = 0; frames = 0;
        last_rd_cyc = -1; last_rd_addr = '0;
    endtask

    // Compare process and datapath responder, once per cycle at the falling edge.
    always @(negedge clk) begin
        item_t it;
        int    exp_start;
        logic [15:0] exp_old;
        bit    exp_disp;
        if (!reset_n) begin
            job_done  = 1'b0;
            busy      = 0;
            frame_exp = 0;
        end else begin
            check("frame_pulse", 32'(frame_pulse), 32'(frame_exp));
            if (frame_pulse) frames++;
            frame_exp = 0;
            job_done  = 1'b0;
            if (stray) begin
                job_done = 1'b1;
                stray    = 0;
            end
            if (hist_rd_en) begin
                check("rd_addr", 32'(hist_rd_addr), 32'(m_ptr));
                last_rd_cyc  = cyc;
                last_rd_addr = hist_rd_addr;
            end
            if (job_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_job_start", 32'(1), 32'(0));
                end else begin
                    it        = exp_q.pop_front();
                    exp_start = (last_done + 3 > it.acc + 4) ? last_done + 3 : it.acc + 4;
                    exp_old   = (m_fill < N) ? 16'h0 : mhist[m_ptr];
                    exp_disp  = (m_dcnt == P - 1);
                    check("start_cycle", 32'(cyc), 32'(exp_start));
                    check("job_sample", 32'(job_sample), 32'(it.v));
                    check("job_oldest", 32'(job_oldest), 32'(exp_old));
                    check("wr_en", 32'(hist_wr_en), 32'(1));
                    check("wr_addr", 32'(hist_wr_addr), 32'(m_ptr));
                    check("wr_data", 32'(hist_wr_data), 32'(it.v));
                    check("disp_wr_en", 32'(disp_wr_en), 32'(exp_disp));
                    if (jobs < MAXJ) begin
                        j_sample[jobs]  = job_sample;
                        j_old[jobs]     = job_oldest;
                        j_wr_addr[jobs] = hist_wr_addr;
                        j_rd_addr[jobs] = last_rd_addr;
                        j_disp[jobs]    = disp_wr_en;
                        j_start[jobs]   = cyc;
                        j_rd_cyc[jobs]  = last_rd_cyc;
                    end
                    mhist[m_ptr] = it.v;
                    cur_disp = exp_disp;
                    jobs++;
                    busy   = 1;
                    cnt_dn = done_dly;
                end
            end else if (busy && !hold) begin
                if (cnt_dn > 1) begin
                    cnt_dn--;
                end else begin
                    job_done  = 1'b1;
                    busy      = 0;
                    last_done = cyc;
                    m_ptr     = (m_ptr + 1) % N;
                    if (m_fill < N) m_fill++;
                    m_dcnt    = (m_dcnt == P - 1) ? 0 : m_dcnt + 1;
                    frame_exp = cur_disp;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'(1));
        check({tag, "_strobes"}, 32'({hist_rd_en, hist_wr_en, job_start, disp_wr_en, frame_pulse}), 32'(0));
        check({tag, "_addrs"}, 32'({hist_rd_addr, hist_wr_addr}), 32'(0));
        check({tag, "_data"}, 32'({job_sample, hist_wr_data}), 32'(0));
        check({tag, "_oldest"}, 32'(job_oldest), 32'(0));
        check({tag, "_drop"}, 32'(drop_count), 32'(0));
    endtask

    task automatic send(input logic [15:0] v, output int t);
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = v;
        t = cyc;
        exp_q.push_back('{v, cyc});
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_jobs(input int n, input int budget);
        int k = 0;
        while (jobs < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("wait_jobs", 32'(jobs), 32'(n));
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain", 32'(busy) + 32'(exp_q.size()), 32'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int t, n_disp, exp_drop;
        bit exp_rdy;
        for (int i = 0; i < N; i++) ram[i] = 16'hDEAD;
        hold = 0; stray = 0; done_dly = 10;
        model_reset();

        // Reset values
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("reset");
        reset_n = 1'b1;

        // Single sample 100, done 10 cycles after start, then a second sample
        send(16'd100, t);
        wait_jobs(1, 50);
        wait_drain(50);
        check("t1_rd_cycle", 32'(j_rd_cyc[0]), 32'(t + 2));
        check("t1_start_cycle", 32'(j_start[0]), 32'(t + 4));
        check("t1_sample", 32'(j_sample[0]), 32'(100));
        check("t1_oldest", 32'(j_old[0]), 32'(0));
        check("t1_wr_addr", 32'(j_wr_addr[0]), 32'(0));
        send(16'd200, t);
        wait_drain(50);
        check("t1_ptr_now_1", 32'(j_wr_addr[1]), 32'(1));
        check("t1_rd_addr_1", 32'(j_rd_addr[1]), 32'(1));

        // Stream of 8820 samples; a stray job_done while idle must be ignored
        do_reset();
        done_dly = 1;
        @(posedge clk); #1 stray = 1;
        repeat (3) @(posedge clk);
        for (int i = 1; i <= 2 * P; i++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = 16'(i);
            exp_q.push_back('{16'(i), cyc});
            @(posedge clk); #1;
            s_valid = 1'b0;
            repeat (3) @(posedge clk);
        end
        wait_drain(100);
        check("stream_jobs", 32'(jobs), 32'(2 * P));
        check("stream_first_addr", 32'(j_wr_addr[0]), 32'(0));
        check("job256_oldest", 32'(j_old[255]), 32'(0));
        check("job257_oldest", 32'(j_old[256]), 32'(1));
        check("job257_rd_addr", 32'(j_rd_addr[256]), 32'(0));
        check("job257_wr_addr", 32'(j_wr_addr[256]), 32'(0));
        check("job4409_disp", 32'(j_disp[P - 2]), 32'(0));
        check("job4410_disp", 32'(j_disp[P - 1]), 32'(1));
        check("job8820_disp", 32'(j_disp[2 * P - 1]), 32'(1));
        n_disp = 0;
        for (int i = 0; i < 2 * P; i++) n_disp += int'(j_disp[i]);
        check("disp_job_count", 32'(n_disp), 32'(2));
        check("frame_count", 32'(frames), 32'(2));

        // Overflow: datapath busy while 6 samples arrive
        do_reset();
        hold = 1;
        done_dly = 1;
        send(16'd11, t);
        wait_jobs(1, 50);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = 16'(21 + k);
            exp_rdy = (k < 4);
            check("ovf_s_ready", 32'(s_ready), 32'(exp_rdy));
            if (exp_rdy) exp_q.push_back('{16'(21 + k), cyc});
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
`ifdef SDFT_DROP_COUNT_EN
        exp_drop = 2;
`else
        exp_drop = 0;
`endif
        check("drop_count", 32'(drop_count), 32'(exp_drop));
        check("ovf_full_hold", 32'(s_ready), 32'(0));
        hold = 0;
        wait_drain(100);
        check("ovf_jobs", 32'(jobs), 32'(5));
        for (int k = 0; k < 4; k++) check("ovf_order", 32'(j_sample[k + 1]), 32'(21 + k));
        check("ovf_ready_back", 32'(s_ready), 32'(1));

        // Reset while a job is in WAIT
        hold = 1;
        send(16'd77, t);
        wait_jobs(6, 50);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset_vals("midjob");
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        hold = 0;
        @(posedge clk); #1;
        check("post_reset_ready", 32'(s_ready), 32'(1));
        send(16'd99, t);
        wait_drain(50);
        check("post_reset_jobs", 32'(jobs), 32'(1));
        check("post_reset_addr", 32'(j_wr_addr[0]), 32'(0));
        check("post_reset_oldest", 32'(j_old[0]), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
